// File: rtl/reg_dump_sequencer_if.sv
// Bundle between reg_dump_sequencer and its neighbours: core start/done handshake,
// register-file debug read port, CPU text-buffer store and the ascii write port.
interface reg_dump_sequencer_if #(
  parameter int unsigned WORD_SIZE = 32,
  parameter int unsigned ADDR_W    = 13
);
  logic                 start;
  logic                 busy;
  logic                 done;
  logic [4:0]           debug_reg;
  logic [WORD_SIZE-1:0] debug_reg_out;
  logic                 cpu_write_en;
  logic [ADDR_W-1:0]    cpu_write_address;
  logic [WORD_SIZE-1:0] cpu_write_data;
  logic                 ascii_write_en;
  logic [ADDR_W-1:0]    ascii_write_address;
  logic [WORD_SIZE-1:0] ascii_input;

  modport master (
    input  start, debug_reg_out, cpu_write_en, cpu_write_address, cpu_write_data,
    output busy, done, debug_reg, ascii_write_en, ascii_write_address, ascii_input
  );

  modport slave (
    output start, debug_reg_out, cpu_write_en, cpu_write_address, cpu_write_data,
    input  busy, done, debug_reg, ascii_write_en, ascii_write_address, ascii_input
  );
endinterface

// File: rtl/reg_dump_sequencer.sv
// Dumps every register as 8 uppercase hex digits, one row each, into the ascii text buffer.
// Optional REG_DUMP_LABEL_EN prefixes each row with "xNN: ".
module reg_dump_sequencer #(
  parameter int unsigned WORD_SIZE = 32,
  parameter int unsigned NUM_REGS  = 32,
  parameter int unsigned COLS      = 80,
  parameter int unsigned ADDR_W    = 13,
  parameter int unsigned BASE_ROW  = 0
) (
  input logic                  clk,
  input logic                  rst,
  reg_dump_sequencer_if.master bus
);

  localparam int unsigned IDX_W = 5;
  localparam int unsigned COL_W = 4;
`ifdef REG_DUMP_LABEL_EN
  localparam int unsigned LABEL_LEN = 5;
`else
  localparam int unsigned LABEL_LEN = 0;
`endif
  localparam int unsigned LAST_COL = LABEL_LEN + 7;

  typedef enum logic [2:0] {
    S_IDLE, S_SET_REG, S_WAIT_REG, S_LATCH, S_EMIT, S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [COL_W-1:0]     col_q, col_d;
  logic [WORD_SIZE-1:0] shift_q, shift_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [IDX_W-1:0]     debug_reg_q, debug_reg_d;
  logic                 wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]    wr_addr_q, wr_addr_d;
  logic [WORD_SIZE-1:0] wr_data_q, wr_data_d;

  logic [3:0]           nib_c;
  logic [7:0]           hex_char_c;
  logic [7:0]           char_c;
  logic                 shift_en_c;
  logic [ADDR_W-1:0]    addr_c;

  assign nib_c      = shift_q[WORD_SIZE-1 -: 4];
  assign hex_char_c = (nib_c < 4'd10) ? (8'h30 + 8'(nib_c)) : (8'h37 + 8'(nib_c));
  assign addr_c     = ADDR_W'((32'(BASE_ROW) + 32'(idx_q)) * 32'(COLS) + 32'(col_q));

  // Character for the current column; the shift register only advances on hex columns
`ifdef REG_DUMP_LABEL_EN
  always_comb begin
    char_c     = hex_char_c;
    shift_en_c = 1'b0;
    case (col_q)
      4'd0:    char_c = 8'h78;
      4'd1:    char_c = 8'h30 + 8'(idx_q / 5'd10);
      4'd2:    char_c = 8'h30 + 8'(idx_q % 5'd10);
      4'd3:    char_c = 8'h3A;
      4'd4:    char_c = 8'h20;
      default: shift_en_c = 1'b1;
    endcase
  end
`else
  assign char_c     = hex_char_c;
  assign shift_en_c = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      col_q       <= '0;
      shift_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      debug_reg_q <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      col_q       <= col_d;
      shift_q     <= shift_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      debug_reg_q <= debug_reg_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
    end
  end

  // CPU store wins the write port every cycle; the dump only advances in EMIT when it is idle
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    col_d       = col_q;
    shift_d     = shift_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    debug_reg_d = debug_reg_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;

    if (bus.cpu_write_en) begin
      wr_en_d   = 1'b1;
      wr_addr_d = bus.cpu_write_address;
      wr_data_d = bus.cpu_write_data;
    end

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_SET_REG;
          idx_d   = '0;
          busy_d  = 1'b1;
        end
      end
      S_SET_REG: begin
        debug_reg_d = idx_q;
        state_d     = S_WAIT_REG;
      end
      S_WAIT_REG: state_d = S_LATCH;
      S_LATCH: begin
        shift_d = bus.debug_reg_out;
        col_d   = '0;
        state_d = S_EMIT;
      end
      S_EMIT: begin
        if (!bus.cpu_write_en) begin
          wr_en_d   = 1'b1;
          wr_addr_d = addr_c;
          wr_data_d = {char_c, {(WORD_SIZE-8){1'b1}}};
          if (shift_en_c) shift_d = {shift_q[WORD_SIZE-5:0], 4'h0};
          if (col_q == COL_W'(LAST_COL)) begin
            if (idx_q == IDX_W'(NUM_REGS - 1)) begin
              state_d = S_DONE;
            end else begin
              idx_d   = idx_q + 1'b1;
              state_d = S_SET_REG;
            end
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.busy                = busy_q;
  assign bus.done                = done_q;
  assign bus.debug_reg           = debug_reg_q;
  assign bus.ascii_write_en      = wr_en_q;
  assign bus.ascii_write_address = wr_addr_q;
  assign bus.ascii_input         = wr_data_q;

endmodule

// File: tb/tb_reg_dump_sequencer.sv
// Directed self-checking bench for reg_dump_sequencer (follows REG_DUMP_LABEL_EN if defined).
module tb_reg_dump_sequencer;

  localparam int unsigned WORD_SIZE = 32;
  localparam int unsigned ADDR_W    = 13;

`ifdef REG_DUMP_LABEL_EN
  localparam int CPR     = 13;
  localparam int DONE_AT = 513;
  logic [7:0] exp5  [CPR] = '{8'h78, 8'h30, 8'h35, 8'h3A, 8'h20,
                              8'h44, 8'h45, 8'h41, 8'h44, 8'h42, 8'h45, 8'h45, 8'h46};
  logic [7:0] exp10 [CPR] = '{8'h78, 8'h31, 8'h30, 8'h3A, 8'h20,
                              8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h41};
  logic [7:0] exp_col2 = 8'h30;
`else
  localparam int CPR     = 8;
  localparam int DONE_AT = 353;
  logic [7:0] exp5  [CPR] = '{8'h44, 8'h45, 8'h41, 8'h44, 8'h42, 8'h45, 8'h45, 8'h46};
  logic [7:0] exp10 [CPR] = '{8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h41};
  logic [7:0] exp_col2 = 8'h32;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  reg_dump_sequencer_if #(.WORD_SIZE(WORD_SIZE), .ADDR_W(ADDR_W)) bus ();

  reg_dump_sequencer #(
    .WORD_SIZE(WORD_SIZE), .NUM_REGS(32), .COLS(80), .ADDR_W(ADDR_W), .BASE_ROW(0)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [31:0] regs [32];
  assign bus.debug_reg_out = regs[bus.debug_reg];

  int n_checks = 0;
  int n_fail   = 0;
  logic [ADDR_W-1:0] log_addr [$];
  logic [31:0]       log_data [$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Start a dump and log every ascii write until done; optional 3-cycle CPU burst and re-start pulse
  task automatic run_dump(input int cpu_at, input int retrig_at, output int done_n);
    log_addr.delete();
    log_data.delete();
    done_n = -1;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check_eq("busy_after_start", 32'(bus.busy), 32'd1);
    for (int n = 1; n <= 2000; n++) begin
      bus.cpu_write_en = (cpu_at >= 0) && (n >= cpu_at) && (n < cpu_at + 3);
      bus.start        = (n == retrig_at);
      @(posedge clk); #1;
      if (bus.ascii_write_en) begin
        log_addr.push_back(bus.ascii_write_address);
        log_data.push_back(bus.ascii_input);
      end
      if (bus.done) begin
        done_n = n;
        break;
      end
    end
    bus.cpu_write_en = 1'b0;
    bus.start        = 1'b0;
    if (done_n < 0) check_eq("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_row(input string tag, input int reg_i, input int base_addr, input int which);
    logic [7:0] ch;
    for (int k = 0; k < CPR; k++) begin
      ch = (which == 5) ? exp5[k] : exp10[k];
      if (reg_i * CPR + k >= log_addr.size()) begin
        check_eq($sformatf("%s_missing_%0d", tag, k), 32'd0, 32'd1);
      end else begin
        check_eq($sformatf("%s_addr_%0d", tag, k), 32'(log_addr[reg_i*CPR+k]), 32'(base_addr + k));
        check_eq($sformatf("%s_data_%0d", tag, k), log_data[reg_i*CPR+k], {ch, 24'hFFFFFF});
      end
    end
  endtask

  int done_n;
  int pulses;

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = 32'h1111_1111 * 32'(i);
    regs[0]  = 32'h0123ABCD;
    regs[5]  = 32'hDEADBEEF;
    regs[10] = 32'h0000000A;
    bus.start             = 1'b0;
    bus.cpu_write_en      = 1'b0;
    bus.cpu_write_address = '0;
    bus.cpu_write_data    = '0;

    // Reset held two cycles
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_busy",    32'(bus.busy), 32'd0);
    check_eq("rst_done",    32'(bus.done), 32'd0);
    check_eq("rst_dbg",     32'(bus.debug_reg), 32'd0);
    check_eq("rst_wen",     32'(bus.ascii_write_en), 32'd0);
    check_eq("rst_waddr",   32'(bus.ascii_write_address), 32'd0);
    check_eq("rst_wdata",   bus.ascii_input, 32'd0);
    rst = 1'b0;

    // Reset in the middle of a dump, with start also pulsed
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    check_eq("mid_busy", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    bus.start = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    bus.start = 1'b0;
    check_eq("abort_busy", 32'(bus.busy), 32'd0);
    check_eq("abort_wen",  32'(bus.ascii_write_en), 32'd0);
    check_eq("abort_dbg",  32'(bus.debug_reg), 32'd0);
    pulses = 0;
    for (int n = 0; n < 600; n++) begin
      @(posedge clk); #1;
      if (bus.done) pulses++;
    end
    check_eq("abort_no_done", 32'(pulses), 32'd0);

    // CPU pass-through while idle, one-cycle latency
    bus.cpu_write_en      = 1'b1;
    bus.cpu_write_address = 13'd77;
    bus.cpu_write_data    = 32'h41FFFFFF;
    #1;
    check_eq("idle_cpu_not_early", 32'(bus.ascii_write_en), 32'd0);
    @(posedge clk); #1;
    bus.cpu_write_en = 1'b0;
    check_eq("idle_cpu_wen",  32'(bus.ascii_write_en), 32'd1);
    check_eq("idle_cpu_addr", 32'(bus.ascii_write_address), 32'd77);
    check_eq("idle_cpu_data", bus.ascii_input, 32'h41FFFFFF);
    @(posedge clk); #1;
    check_eq("idle_cpu_one_cycle", 32'(bus.ascii_write_en), 32'd0);

    // Plain dump
    run_dump(-1, -1, done_n);
    check_eq("dump_done_cycle", 32'(done_n), 32'(DONE_AT));
    check_eq("dump_write_count", 32'(log_addr.size()), 32'(32 * CPR));
    check_row("reg5", 5, 400, 5);
    check_row("reg10", 10, 800, 10);
    @(posedge clk); #1;
    check_eq("done_one_cycle", 32'(bus.done), 32'd0);
    check_eq("busy_after_done", 32'(bus.busy), 32'd0);

    // CPU contention for 3 cycles while row 0 is being emitted
    bus.cpu_write_address = 13'd1000;
    bus.cpu_write_data    = 32'h58FFFFFF;
    run_dump(6, -1, done_n);
    check_eq("cont_done_cycle", 32'(done_n), 32'(DONE_AT + 3));
    check_eq("cont_write_count", 32'(log_addr.size()), 32'(32 * CPR + 3));
    check_eq("cont_pre_addr", 32'(log_addr[1]), 32'd1);
    for (int k = 2; k < 5; k++) begin
      check_eq($sformatf("cont_cpu_addr_%0d", k), 32'(log_addr[k]), 32'd1000);
      check_eq($sformatf("cont_cpu_data_%0d", k), log_data[k], 32'h58FFFFFF);
    end
    check_eq("cont_resume_addr", 32'(log_addr[5]), 32'd2);
    check_eq("cont_resume_data", log_data[5], {exp_col2, 24'hFFFFFF});
    @(posedge clk); #1;

    // Re-start while busy is ignored; start right after done gives a second full dump
    run_dump(-1, 50, done_n);
    check_eq("retrig_done_cycle", 32'(done_n), 32'(DONE_AT));
    run_dump(-1, -1, done_n);
    check_eq("back2back_done_cycle", 32'(done_n), 32'(DONE_AT));
    check_eq("back2back_write_count", 32'(log_addr.size()), 32'(32 * CPR));
    check_row("b2b_reg5", 5, 400, 5);
    @(posedge clk); #1;
    check_eq("final_busy", 32'(bus.busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
